// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller in front of the datapath ALU.
// Accepts one decoded MIPS instruction per handshake, drives the ALU for
// exactly one cycle (EXEC), captures the result and presents it to the next
// stage on a valid/ready handshake (RESP).
// Optional feature macro: ALU_ISSUE_BACK2BACK_EN -- allows a new packet to be
// accepted on the same edge that the current result is consumed (RESP->EXEC).
module alu_issue_ctrl #(
  parameter int DATA_W = 32  // ALU interface is fixed at 32 bits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic [3:0]        alu_ct,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [1:0]        out_kind,
  output logic              out_taken,
  output logic [7:0]        illegal_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CT_NOP = 4'b0000;
  localparam logic [3:0] CT_ADD = 4'b0010;
  localparam logic [3:0] CT_SUB = 4'b0110;

  localparam logic [1:0] K_REG = 2'b00;
  localparam logic [1:0] K_MEM = 2'b01;
  localparam logic [1:0] K_BR  = 2'b10;
  localparam logic [1:0] K_ILL = 2'b11;

  state_t              state_q, state_d;
  logic [3:0]          alu_ct_q, alu_ct_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [1:0]          kind_pend_q, kind_pend_d;  // kind of the packet in EXEC
  logic                bne_q, bne_d;              // invert zero flag for bne
  logic [DATA_W-1:0]   out_res_q, out_res_d;
  logic [1:0]          out_kind_q, out_kind_d;
  logic                out_taken_q, out_taken_d;
  logic [7:0]          illegal_cnt_q, illegal_cnt_d;

  // Decode results for the packet currently on the input port
  logic [5:0]          dec_opcode;
  logic [5:0]          dec_funct;
  logic [DATA_W-1:0]   dec_imm_sext;
  logic [3:0]          dec_ct;
  logic [DATA_W-1:0]   dec_src1;
  logic [DATA_W-1:0]   dec_src2;
  logic [1:0]          dec_kind;
  logic                dec_bne;
  logic                accept;

  // Register-number fields are resolved upstream; only opcode/funct/imm matter here
  logic                unused_instr_bits;
  assign unused_instr_bits = ^in_instr[25:16];

  // Instruction decode: pick ALU op, operands and result class
  always_comb begin
    dec_opcode   = in_instr[31:26];
    dec_funct    = in_instr[5:0];
    dec_imm_sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    dec_ct       = CT_NOP;
    dec_src1     = '0;
    dec_src2     = '0;
    dec_kind     = K_ILL;
    dec_bne      = 1'b0;
    case (dec_opcode)
      6'b000000: begin
        if (dec_funct == 6'b100000) begin
          dec_ct   = CT_ADD;
          dec_src1 = in_rs_val;
          dec_src2 = in_rt_val;
          dec_kind = K_REG;
        end else if (dec_funct == 6'b100010) begin
          dec_ct   = CT_SUB;
          dec_src1 = in_rs_val;
          dec_src2 = in_rt_val;
          dec_kind = K_REG;
        end
      end
      6'b100011, 6'b101011: begin
        dec_ct   = CT_ADD;
        dec_src1 = in_rs_val;
        dec_src2 = dec_imm_sext;
        dec_kind = K_MEM;
      end
      6'b000100: begin
        dec_ct   = CT_SUB;
        dec_src1 = in_rs_val;
        dec_src2 = in_rt_val;
        dec_kind = K_BR;
      end
      6'b000101: begin
        dec_ct   = CT_SUB;
        dec_src1 = in_rs_val;
        dec_src2 = in_rt_val;
        dec_kind = K_BR;
        dec_bne  = 1'b1;
      end
      default: ;
    endcase
  end

  // Input readiness from registered state (plus out_ready in back-to-back mode)
  always_comb begin
`ifdef ALU_ISSUE_BACK2BACK_EN
    in_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && out_ready);
`else
    in_ready = (state_q == S_IDLE);
`endif
    accept = in_valid && in_ready;
  end

  // Next-state logic: ALU drive is zero unless the next cycle is EXEC
  always_comb begin
    state_d       = state_q;
    alu_ct_d      = CT_NOP;
    src1_d        = '0;
    src2_d        = '0;
    kind_pend_d   = kind_pend_q;
    bne_d         = bne_q;
    out_res_d     = out_res_q;
    out_kind_d    = out_kind_q;
    out_taken_d   = out_taken_q;
    illegal_cnt_d = illegal_cnt_q;

    case (state_q)
      S_EXEC: begin
        // Illegal packets never look at alu_res; the ALU may output anything
        out_res_d   = (kind_pend_q == K_ILL) ? '0 : alu_res;
        out_kind_d  = kind_pend_q;
        out_taken_d = (kind_pend_q == K_BR) ? (alu_zero ^ bne_q) : 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the case above so RESP->EXEC works in back-to-back mode
    if (accept) begin
      state_d     = S_EXEC;
      alu_ct_d    = dec_ct;
      src1_d      = dec_src1;
      src2_d      = dec_src2;
      kind_pend_d = dec_kind;
      bne_d       = dec_bne;
      if ((dec_kind == K_ILL) && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
    end
  end

  // State and output registers; reset aborts any in-flight packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alu_ct_q      <= CT_NOP;
      src1_q        <= '0;
      src2_q        <= '0;
      kind_pend_q   <= K_REG;
      bne_q         <= 1'b0;
      out_res_q     <= '0;
      out_kind_q    <= K_REG;
      out_taken_q   <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      alu_ct_q      <= alu_ct_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      kind_pend_q   <= kind_pend_d;
      bne_q         <= bne_d;
      out_res_q     <= out_res_d;
      out_kind_q    <= out_kind_d;
      out_taken_q   <= out_taken_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign alu_ct      = alu_ct_q;
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign out_valid   = (state_q == S_RESP);
  assign out_res     = out_res_q;
  assign out_kind    = out_kind_q;
  assign out_taken   = out_taken_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural ALU,
// a scoreboard queue filled at accept and a monitor that pops on each result.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  kind;
    logic        taken;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [3:0]  alu_ct;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [1:0]  out_kind;
  logic        out_taken;
  logic [7:0]  illegal_cnt;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  alu_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .alu_ct(alu_ct), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_kind(out_kind), .out_taken(out_taken), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; idle code returns junk so illegal packets prove they ignore it
  always_comb begin
    case (alu_ct)
      4'b0010: alu_res = alu_src1 + alu_src2;
      4'b0110: alu_res = alu_src1 - alu_src2;
      default: alu_res = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic [1:0] kind, input logic taken);
    exp_t e;
    e.res = res; e.kind = kind; e.taken = taken;
    return e;
  endfunction

  function automatic logic [31:0] r_type(input logic [5:0] funct);
    return {6'b000000, 20'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  // Monitor: every consumed result is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got res %h kind %b with nothing expected", out_res, out_kind);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_res", out_res, e.res);
        chk("out_kind", {30'd0, out_kind}, {30'd0, e.kind});
        chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
        $display("result res=%h kind=%b taken=%b", out_res, out_kind, out_taken);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_res"}, out_res, 32'd0);
    chk({tag, "_out_kind"}, {30'd0, out_kind}, 32'd0);
    chk({tag, "_out_taken"}, {31'd0, out_taken}, 32'd0);
    chk({tag, "_alu_ct"}, {28'd0, alu_ct}, 32'd0);
    chk({tag, "_alu_src1"}, alu_src1, 32'd0);
    chk({tag, "_alu_src2"}, alu_src2, 32'd0);
    chk({tag, "_illegal_cnt"}, {24'd0, illegal_cnt}, 32'd0);
  endtask

  // Present a packet until accepted; returns #1 after the accept edge (EXEC cycle)
  task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                      input logic push, input exp_t e);
    int waited = 0;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    prev_acc = last_acc;
    last_acc = cyc;
    in_valid = 1'b0;
    if (push) sb_q.push_back(e);
    $display("accept instr=%h rs=%h rt=%h cyc=%0d", instr, rs, rt, cyc);
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs_val = '0; in_rt_val = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // add 5+7: ALU driven in EXEC, result 2 cycles after accept
    send(r_type(6'b100000), 32'd5, 32'd7, 1'b1, mk(32'd12, 2'b00, 1'b0));
    chk("add_alu_ct", {28'd0, alu_ct}, 32'h2);
    chk("add_src1", alu_src1, 32'd5);
    chk("add_src2", alu_src2, 32'd7);
    chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
    chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("resp_alu_ct_idle", {28'd0, alu_ct}, 32'd0);
    chk("resp_src1_zero", alu_src1, 32'd0);
    drain();

    // sub with wrap, lw with negative immediate, beq/bne
    send(r_type(6'b100010), 32'd0, 32'd1, 1'b1, mk(32'hFFFF_FFFF, 2'b00, 1'b0));
    chk("sub_alu_ct", {28'd0, alu_ct}, 32'h6);
    send(i_type(6'b100011, 16'hFFFC), 32'h100, 32'h55, 1'b1, mk(32'h0000_00FC, 2'b01, 1'b0));
    chk("lw_src2", alu_src2, 32'hFFFF_FFFC);
    chk("lw_alu_ct", {28'd0, alu_ct}, 32'h2);
    send(i_type(6'b101011, 16'h0010), 32'h200, 32'h0, 1'b1, mk(32'h0000_0210, 2'b01, 1'b0));
    send(i_type(6'b000100, 16'h0004), 32'd9, 32'd9, 1'b1, mk(32'd0, 2'b10, 1'b1));
    send(i_type(6'b000101, 16'h0004), 32'd9, 32'd9, 1'b1, mk(32'd0, 2'b10, 1'b0));
    send(i_type(6'b000101, 16'h0004), 32'd9, 32'd4, 1'b1, mk(32'd5, 2'b10, 1'b1));
    drain();

    // Back-pressure: result held stable for 5 cycles
    out_ready = 1'b0;
    send(r_type(6'b100000), 32'd1, 32'd2, 1'b1, mk(32'd3, 2'b00, 1'b0));
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_res", out_res, 32'd3);
      chk("bp_out_kind", {30'd0, out_kind}, 32'd0);
      chk("bp_out_taken", {31'd0, out_taken}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-EXEC: in-flight packet dropped, outputs back to reset values at once
    send(r_type(6'b100000), 32'd10, 32'd20, 1'b0, mk(32'd0, 2'b00, 1'b0));
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Illegal opcode 260 times: counter saturates, ALU stays idle
    for (int i = 0; i < 260; i++) begin
      send(i_type(6'b111111, i[15:0]), i, ~i, 1'b1, mk(32'd0, 2'b11, 1'b0));
      chk("ill_alu_ct", {28'd0, alu_ct}, 32'd0);
      chk("ill_src1", alu_src1, 32'd0);
      chk("ill_src2", alu_src2, 32'd0);
      chk("ill_cnt", {24'd0, illegal_cnt}, (i + 1 > 255) ? 32'd255 : i + 1);
      if (i > 0) begin
`ifdef ALU_ISSUE_BACK2BACK_EN
        chk("accept_interval", last_acc - prev_acc, 32'd2);
`else
        chk("accept_interval", last_acc - prev_acc, 32'd3);
`endif
      end
    end
    drain();
    chk("ill_cnt_final", {24'd0, illegal_cnt}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits on the control side of the datapath ALU. It accepts one decoded-instruction packet per handshake and selects the ALU operation code and operands. It drives them onto the ALU's `alu_ct`/`alu_src1`/`alu_src2` inputs for exactly one cycle, then captures `alu_res`/`alu_zero`. It returns a classified result (register write, memory address, or branch decision) to the downstream stage through a valid/ready handshake.

## Interface
- `DATA_W`, default 32: operand/result width; the ALU interface is fixed at 32, so only 32 is legal.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction packet valid.
- `in_ready`  out  1  controller can accept a packet.
- `in_instr`  in  32  MIPS word: opcode `[31:26]`, funct `[5:0]`, imm `[15:0]`.
- `in_rs_val`  in  32  rs operand value.
- `in_rt_val`  in  32  rt operand value.
- `alu_ct`  out  4  ALU operation: 4'b0010 add, 4'b0110 sub, 4'b0000 idle/illegal.
- `alu_src1`  out  32  ALU operand A.
- `alu_src2`  out  32  ALU operand B.
- `alu_res`  in  32  ALU combinational result.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  result packet valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_res`  out  32  captured `alu_res`.
- `out_kind`  out  2  2'b00 reg-write, 2'b01 mem-address, 2'b10 branch, 2'b11 illegal.
- `out_taken`  out  1  branch decision; 0 unless `out_kind`=2'b10.
- `illegal_cnt`  out  8  count of illegal instructions; saturates at 255.

## Operation
- Decode rules, applied at accept:
  - opcode 000000 with funct 100000: add rs+rt, kind 00.
  - opcode 000000 with funct 100010: sub rs−rt, kind 00.
  - opcode 100011 (lw) or 101011 (sw): add rs + sign-extended imm, kind 01.
  - opcode 000100 (beq): sub rs−rt; `out_taken` = `alu_zero`.
  - opcode 000101 (bne): sub rs−rt; `out_taken` = !`alu_zero`.
  - Anything else: illegal. `alu_ct` = 0000, operands 0, kind 11, `out_res` 0, `illegal_cnt` incremented unless already 255.
- FSM has three states:
  - IDLE: `in_ready`=1. On `in_valid`, latch decode and operands, go to EXEC.
  - EXEC: drive `alu_ct`/`alu_src1`/`alu_src2` from the latched values. At the end of the cycle, capture `alu_res` and `alu_zero` into output registers and go to RESP.
  - RESP: `out_valid`=1. Outputs stay stable until `out_ready`, then go to IDLE.
- Outside EXEC, `alu_ct`=0000 and both ALU operands are 0.
- Arithmetic is modulo 2^32; the controller does no overflow detection.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_res`=0, `out_kind`=00, `out_taken`=0, `alu_ct`=0000, `alu_src1`=0, `alu_src2`=0, `illegal_cnt`=0.
- Asserting `rst` at any point aborts the in-flight packet with no output.

## Timing
- A packet accepted at edge k is in EXEC during cycle k→k+1. `out_valid` rises after edge k+1.
- Minimum latency is 2 cycles from accept to `out_valid`. Base throughput is one packet per 3 cycles.
- `in_ready` is 0 throughout EXEC and RESP in the base build.
- `out_*` must not change while `out_valid`=1 and `out_ready`=0.
- `alu_res` is sampled only at the EXEC→RESP edge. ALU input changes in other cycles have no effect.
- `in_ready` is a function of the registered state only. It has no combinational path from `in_valid`.

## Configuration
- `ALU_ISSUE_BACK2BACK_EN` defined:
  - In RESP with `out_ready`=1, `in_ready`=1.
  - If `in_valid` is also 1, the new packet is accepted on the same edge and the FSM goes RESP→EXEC, skipping IDLE.
  - Sustained throughput is one packet per 2 cycles.
  - In this build `in_ready` depends combinationally on `out_ready`.
- Undefined: RESP always returns to IDLE. `in_ready`=0 in RESP.

## Test plan
- Reset, then add: rs=5, rt=7, funct 100000. Expect `alu_ct`=0010 in the EXEC cycle. Then `out_valid` with `out_res`=12, kind 00, 2 cycles after accept.
- sub with wrap: rs=0, rt=1. Expect `out_res`=32'hFFFF_FFFF, kind 00.
- lw: rs=32'h100, imm 16'hFFFC. Expect `alu_src2`=32'hFFFF_FFFC, `out_res`=32'hFC, kind 01.
- beq with rs=rt=9, then bne with rs=rt=9. Expect `out_taken`=1 for beq and 0 for bne, both kind 10.
- Back-pressure and reset:
  - Hold `out_ready`=0 for 5 cycles: `out_*` stable and `in_ready`=0 throughout.
  - Assert `rst` mid-EXEC: all outputs return to reset values immediately and no result is emitted.
- Illegal opcode 111111 repeated 260 times. Expect kind 11, `alu_ct` stays 0000, and `illegal_cnt` saturates at 255. With `ALU_ISSUE_BACK2BACK_EN` defined and `out_ready`=1, accepts occur every 2 cycles.
